// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one serial transmitter between NUM_REQ byte sources.
//            Arbitration is round-robin and runs only while idle. The winning
//            byte is handed to the transmitter with a one-cycle load strobe.
//            The block then times the whole frame plus a guard gap, because
//            the transmitter core has no busy output of its own.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-low reset
//            req_valid  - per-requester byte valid
//            req_data   - per-requester byte, requester i on [8i+7:8i]
//            req_ready  - one-hot acceptance pulse to the granted requester
//            tx_en      - one-cycle load strobe to the transmitter
//            tx_data    - byte to the transmitter, held until the next load
//            grant_id   - index of the last granted requester
//            busy       - high from grant until the end of the guard gap
// Options  : UART_ARB_FIXED_PRIO_EN - when defined, the lowest index always
//            wins and the round-robin pointer is frozen at 0.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 868,
    parameter int FRAME_BITS   = 11,
    parameter int GUARD_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_en,
    output logic [7:0]           tx_data,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    localparam int c_CW       = $clog2(CLKS_PER_BIT);
    localparam int c_BITS_MAX = (FRAME_BITS > GUARD_BITS) ? FRAME_BITS : GUARD_BITS;
    localparam int c_BW       = (c_BITS_MAX > 1) ? $clog2(c_BITS_MAX) : 1;

    localparam logic [c_CW-1:0] c_CYC_LAST   = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_BW-1:0] c_FRAME_LAST = c_BW'(FRAME_BITS - 1);
    localparam logic [c_BW-1:0] c_GAP_LAST   = c_BW'((GUARD_BITS > 0) ? GUARD_BITS - 1 : 0);
    localparam logic [2:0]      c_REQ_LAST   = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [c_CW-1:0] r_cyc,   w_cyc_nxt;
    logic [c_BW-1:0] r_bit,   w_bit_nxt;
    logic [2:0]      r_ptr,   w_ptr_nxt;
    logic [2:0]      r_grant, w_grant_nxt;
    logic [7:0]      r_data,  w_data_nxt;

    // Requester vectors padded to the full 3-bit index range so that the
    // variable selects below never index past the end of a vector.
    logic [7:0]  w_valid_pad;
    logic [63:0] w_data_pad;
    logic [3:0]  w_sum;
    logic        w_any;
    logic [2:0]  w_sel;

    assign w_valid_pad = 8'(req_valid);
    assign w_data_pad  = 64'(req_data);

    // Search from the pointer upward with wrap. Walking the offsets from the
    // highest down lets the smallest offset with a valid request win last.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_ptr;
        w_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_ptr} + 4'(k);
            if (w_sum >= 4'(NUM_REQ)) begin
                w_sum = w_sum - 4'(NUM_REQ);
            end
            if (w_valid_pad[w_sum[2:0]]) begin
                w_any = 1'b1;
                w_sel = w_sum[2:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc   <= '0;
            r_bit   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_data  <= '0;
        end else begin
            r_cyc   <= w_cyc_nxt;
            r_bit   <= w_bit_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_data  <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_bit_nxt   = r_bit;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_data_nxt  = r_data;
        tx_en       = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_any) begin
                    // The grant is committed here; a requester that drops
                    // valid before LOAD still gets this byte sent.
                    w_grant_nxt = w_sel;
                    w_data_nxt  = w_data_pad[{w_sel, 3'b000} +: 8];
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tx_en = 1'b1;
`ifdef UART_ARB_FIXED_PRIO_EN
                w_ptr_nxt = r_ptr;
`else
                w_ptr_nxt = (r_grant == c_REQ_LAST) ? 3'd0 : r_grant + 3'd1;
`endif
                w_cyc_nxt   = '0;
                w_bit_nxt   = '0;
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (r_cyc == c_CYC_LAST) begin
                    w_cyc_nxt = '0;
                    if (r_bit == c_FRAME_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (GUARD_BITS > 0) ? ST_GAP : ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cyc == c_CYC_LAST) begin
                    w_cyc_nxt = '0;
                    if (r_bit == c_GAP_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (r_state == ST_LOAD) && (r_grant == 3'(gi));
        end
    endgenerate

    assign tx_data  = r_data;
    assign grant_id = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter with CLKS_PER_BIT=4.
//            A reference model tracks the arbitration pointer and predicts
//            each grant, its byte and its timing from the frame arithmetic.
// Options  : UART_ARB_FIXED_PRIO_EN selects the fixed-priority model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int CPB      = 4;
    localparam int FRAME    = 11;
    localparam int GUARD    = 1;
    localparam int SPACING  = 2 + (FRAME + GUARD) * CPB;
    localparam int BUSY_LEN = 1 + (FRAME + GUARD) * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [7:0]  d [4];
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic [2:0]  grant_id;
    logic        busy;

    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;

    assign req_data = {d[3], d[2], d[1], d[0]};

    uart_tx_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .CLKS_PER_BIT(CPB),
        .FRAME_BITS  (FRAME),
        .GUARD_BITS  (GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .tx_en    (tx_en),
        .tx_data  (tx_data),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference arbitration: first valid index at or after the pointer.
    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return 0;
    endfunction

    task automatic model_grant(input int g);
`ifdef UART_ARB_FIXED_PRIO_EN
        m_ptr = 0;
`else
        m_ptr = (g + 1) % NUM_REQ;
`endif
    endtask

    // Waits for a load strobe; also counts req_ready pulses seen without one.
    task automatic wait_load(input int bound, output int t, output bit ok, output int stray);
        ok = 0; t = 0; stray = 0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            if (tx_en === 1'b1) begin
                ok = 1; t = cyc;
            end else if (req_ready !== 4'b0) begin
                stray++;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 0;
        for (int k = 0; k < bound && !ok; k++) begin
            @(negedge clk);
            if (busy === 1'b0) ok = 1;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL %s req_ready: got %b want 0000", tag, req_ready); end
        n_vec++; if (tx_en !== 1'b0)     begin n_err++; $display("FAIL %s tx_en: got %b want 0", tag, tx_en); end
        n_vec++; if (tx_data !== 8'h00)  begin n_err++; $display("FAIL %s tx_data: got %h want 00", tag, tx_data); end
        n_vec++; if (grant_id !== 3'd0)  begin n_err++; $display("FAIL %s grant_id: got %0d want 0", tag, grant_id); end
        n_vec++; if (busy !== 1'b0)      begin n_err++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    endtask

    task automatic test_reset();
        int stray;
        rst = 1'b0; req_valid = 4'b0;
        for (int i = 0; i < 4; i++) d[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b1; m_ptr = 0; stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx_en !== 1'b0) stray++;
        end
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL reset_idle: got %0d active cycles want 0", stray); end
    endtask

    task automatic test_single();
        int t, stray, cnt, bad; bit ok, done;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        d[2] = 8'hA5; req_valid = 4'b0100;
        wait_load(100, t, ok, stray);
        n_vec++; if (!ok) begin n_err++; $display("FAIL single_load: got timeout want tx_en"); end
        n_vec++; if (grant_id !== 3'd2)     begin n_err++; $display("FAIL single_grant: got %0d want 2", grant_id); end
        n_vec++; if (tx_data !== 8'hA5)     begin n_err++; $display("FAIL single_data: got %h want a5", tx_data); end
        n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", req_ready); end
        model_grant(2);
        req_valid = 4'b0; d[2] = 8'($urandom);
        cnt = 1; bad = 0; done = 0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (busy === 1'b1) begin
                cnt++;
                if (tx_en !== 1'b0 || req_ready !== 4'b0) bad++;
            end else done = 1;
        end
        n_vec++; if (cnt != BUSY_LEN) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", cnt, BUSY_LEN); end
        n_vec++; if (bad != 0)        begin n_err++; $display("FAIL single_stray: got %0d want 0", bad); end
        n_vec++; if (tx_data !== 8'hA5) begin n_err++; $display("FAIL single_hold: got %h want a5", tx_data); end
    endtask

    // Runs n back-to-back grants with the given mask held, checking each
    // against the model and the fixed grant-to-grant spacing.
    task automatic run_grants(input string tag, input logic [3:0] mask, input int n);
        int t, tp, stray, e; bit ok;
        logic [3:0] er;
        req_valid = mask; tp = -1;
        for (int g = 0; g < n; g++) begin
            e = pick(req_valid, m_ptr);
            er = 4'b0001 << e;
            wait_load(200, t, ok, stray);
            n_vec++; if (!ok) begin n_err++; $display("FAIL %s_load%0d: got timeout want tx_en", tag, g); end
            n_vec++; if (grant_id !== 3'(e)) begin n_err++; $display("FAIL %s_grant%0d: got %0d want %0d", tag, g, grant_id, e); end
            n_vec++; if (tx_data !== d[e])   begin n_err++; $display("FAIL %s_data%0d: got %h want %h", tag, g, tx_data, d[e]); end
            n_vec++; if (req_ready !== er)   begin n_err++; $display("FAIL %s_ready%0d: got %b want %b", tag, g, req_ready, er); end
            n_vec++; if (stray != 0)         begin n_err++; $display("FAIL %s_stray%0d: got %0d want 0", tag, g, stray); end
            if (tp >= 0) begin
                n_vec++; if (t - tp != SPACING) begin n_err++; $display("FAIL %s_spacing%0d: got %0d want %0d", tag, g, t - tp, SPACING); end
            end
            tp = t;
            model_grant(e);
            d[e] = 8'($urandom);
        end
    endtask

    task automatic test_wrap_skip();
        bit ok;
        d[0] = 8'($urandom); d[2] = 8'($urandom);
        run_grants("wrap", 4'b0101, 2);
        req_valid = 4'b0;
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_idle: got busy want idle"); end
    endtask

    task automatic test_late_arrival();
        int t0, t1, stray, e, early; bit ok;
        d[0] = 8'($urandom); req_valid = 4'b0001;
        e = pick(req_valid, m_ptr);
        wait_load(100, t0, ok, stray);
        n_vec++; if (!ok || grant_id !== 3'(e)) begin n_err++; $display("FAIL late_first: got %0d want %0d", grant_id, e); end
        model_grant(e);
        req_valid = 4'b0; early = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_en !== 1'b0) early++;
        end
        d[1] = 8'($urandom); req_valid = 4'b0010;
        e = pick(req_valid, m_ptr);
        wait_load(200, t1, ok, stray);
        n_vec++; if (!ok || t1 - t0 != SPACING) begin n_err++; $display("FAIL late_spacing: got %0d want %0d", t1 - t0, SPACING); end
        n_vec++; if (grant_id !== 3'(e) || tx_data !== d[1]) begin n_err++; $display("FAIL late_grant: got %0d/%h want %0d/%h", grant_id, tx_data, e, d[1]); end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL late_stray: got %0d want 0", early); end
        model_grant(e);
        req_valid = 4'b0;
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL late_idle: got busy want idle"); end
    endtask

    task automatic test_mid_reset();
        int t, stray, act; bit ok;
        d[3] = 8'($urandom); req_valid = 4'b1000;
        wait_load(100, t, ok, stray);
        n_vec++; if (!ok || grant_id !== 3'd3) begin n_err++; $display("FAIL midrst_grant: got %0d want 3", grant_id); end
        req_valid = 4'b0;
        repeat (10) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_send: got busy=%b want 1", busy); end
        @(posedge clk); #2; rst = 1'b0; #1;
        check_outputs_zero("midrst");
        @(negedge clk); rst = 1'b1; m_ptr = 0; act = 0;
        repeat (30) begin
            @(negedge clk);
            if (busy !== 1'b0) act++;
        end
        n_vec++; if (act != 0) begin n_err++; $display("FAIL midrst_after: got %0d busy cycles want 0", act); end
    endtask

    task automatic test_round_robin();
        bit ok;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        run_grants("rr", 4'b1111, 5);
        req_valid = 4'b0;
        wait_idle(200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL rr_idle: got busy want idle"); end
    endtask

`ifdef UART_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        int t, stray, starved; bit ok;
        d[0] = 8'($urandom); d[3] = 8'($urandom);
        req_valid = 4'b1001; starved = 0;
        for (int g = 0; g < 4; g++) begin
            wait_load(200, t, ok, stray);
            n_vec++; if (!ok || grant_id !== 3'd0) begin n_err++; $display("FAIL fixed_grant%0d: got %0d want 0", g, grant_id); end
            if (req_ready[3] !== 1'b0) starved++;
            d[0] = 8'($urandom);
        end
        n_vec++; if (starved != 0) begin n_err++; $display("FAIL fixed_req3: got %0d readies want 0", starved); end
        req_valid = 4'b0;
        wait_idle(200, ok);
    endtask
`endif

    task automatic test_random();
        int t, tp, stray, e; bit ok;
        logic [3:0] er;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        req_valid = 4'($urandom_range(1, 15)); tp = -1;
        for (int g = 0; g < 12; g++) begin
            e = pick(req_valid, m_ptr);
            er = 4'b0001 << e;
            wait_load(200, t, ok, stray);
            n_vec++; if (!ok || grant_id !== 3'(e)) begin n_err++; $display("FAIL rand_grant%0d: got %0d want %0d", g, grant_id, e); end
            n_vec++; if (tx_data !== d[e] || req_ready !== er) begin n_err++; $display("FAIL rand_xfer%0d: got %h/%b want %h/%b", g, tx_data, req_ready, d[e], er); end
            if (tp >= 0) begin
                n_vec++; if (t - tp != SPACING) begin n_err++; $display("FAIL rand_spacing%0d: got %0d want %0d", g, t - tp, SPACING); end
            end
            tp = t;
            model_grant(e);
            // Granted source takes a new byte or retires; others may join.
            d[e] = 8'($urandom);
            req_valid[e] = 1'($urandom);
            req_valid = req_valid | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if (req_valid == 4'b0) req_valid[$urandom_range(0, 3)] = 1'b1;
        end
        req_valid = 4'b0;
        wait_idle(200, ok);
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap_skip();
        test_late_arrival();
        test_mid_reset();
        test_round_robin();
`ifdef UART_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
